// File: rtl/cpu_memory_responder.sv
// Memory-side responder: boot-time byte-stream loader into instruction memory, plus a
// data memory for CPU loads/stores with sticky misalignment/range fault capture.
module cpu_memory_responder #(
    parameter int unsigned INSTR_WORDS = 256,
    parameter int unsigned DATA_WORDS  = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [7:0]  load_byte_i,
    input  logic        load_last_i,
    output logic        cpu_rst_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_o,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] mem_write_data_i,
    input  logic        mem_read_en_i,
    input  logic        mem_write_en_i,
    output logic [31:0] mem_read_data_o,
    output logic [15:0] loaded_words_o,
    output logic        load_overflow_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o
);

    localparam int unsigned IPtrW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int unsigned DPtrW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        asm_q, asm_d;
    logic [IPtrW-1:0]   word_ptr_q, word_ptr_d;
    logic [15:0]        loaded_words_q, loaded_words_d;
    logic               overflow_q, overflow_d;
    logic               fault_q, fault_d;
    logic [31:0]        fault_addr_q, fault_addr_d;
    logic               cpu_rst_q;

    logic [31:0]        imem [INSTR_WORDS];
    logic [31:0]        dmem [DATA_WORDS];

    logic               imem_we;
    logic [31:0]        imem_wdata;
    logic [31:0]        word_w;
    logic [4:0]         shamt;

    logic               instr_in_range;
    logic               d_legal;
    logic               d_fault;
    logic               dmem_we;

    // Byte n of a word lands at bit 8*(3-n), i.e. big-endian assembly.
    assign shamt  = {~byte_cnt_q, 3'b000};
    assign word_w = asm_q | ({24'b0, load_byte_i} << shamt);

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        word_ptr_d     = word_ptr_q;
        loaded_words_d = loaded_words_q;
        overflow_d     = overflow_q;
        imem_we        = 1'b0;
        imem_wdata     = word_w;
        unique case (state_q)
            StLoad: begin
                if (load_valid_i) begin
                    if (byte_cnt_q == 2'd3 || load_last_i) begin
                        imem_we        = 1'b1;
                        asm_d          = 32'b0;
                        byte_cnt_d     = 2'd0;
                        word_ptr_d     = word_ptr_q + 1'b1;
                        loaded_words_d = loaded_words_q + 16'd1;
                        if (load_last_i) begin
                            state_d = StRun;
                        end else if (word_ptr_q == IPtrW'(INSTR_WORDS - 1)) begin
                            overflow_d = 1'b1;
                            state_d    = StRun;
                        end
                    end else begin
                        asm_d      = word_w;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StRun: ;
            default: state_d = StLoad;
        endcase
    end

    // Data access legality and fault capture.
    assign d_legal = (data_addr_i[1:0] == 2'b00) &&
                     ({2'b00, data_addr_i[31:2]} < 32'(DATA_WORDS));
    // Stores while loading are dropped silently; only reads can fault in LOAD.
    assign d_fault = !d_legal &&
                     (mem_read_en_i || (mem_write_en_i && state_q == StRun));
    assign dmem_we = d_legal && mem_write_en_i && (state_q == StRun);

    always_comb begin
        fault_d      = fault_q | d_fault;
        fault_addr_d = fault_addr_q;
        if (d_fault && !fault_q) begin
            fault_addr_d = data_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StLoad;
            byte_cnt_q     <= 2'd0;
            asm_q          <= 32'b0;
            word_ptr_q     <= '0;
            loaded_words_q <= 16'd0;
            overflow_q     <= 1'b0;
            fault_q        <= 1'b0;
            fault_addr_q   <= 32'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            word_ptr_q     <= word_ptr_d;
            loaded_words_q <= loaded_words_d;
            overflow_q     <= overflow_d;
            fault_q        <= fault_d;
            fault_addr_q   <= fault_addr_d;
            cpu_rst_q      <= (state_q != StRun);
        end
    end

    // Memories carry no reset: contents survive rst.
    always_ff @(posedge clk_i) begin
        if (!rst_i && imem_we) begin
            imem[word_ptr_q] <= imem_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && dmem_we) begin
            dmem[data_addr_i[DPtrW+1:2]] <= mem_write_data_i;
        end
    end

    assign instr_in_range = ({2'b00, instr_addr_i[31:2]} < 32'(INSTR_WORDS));

    always_comb begin
        instr_o = 32'b0;
        if (state_q == StRun && instr_in_range) begin
            instr_o = imem[instr_addr_i[IPtrW+1:2]];
        end
    end

    always_comb begin
        mem_read_data_o = 32'b0;
        if (d_legal && mem_read_en_i) begin
            mem_read_data_o = dmem[data_addr_i[DPtrW+1:2]];
        end
    end

    assign load_ready_o    = (state_q == StLoad);
    assign cpu_rst_o       = cpu_rst_q;
    assign loaded_words_o  = loaded_words_q;
    assign load_overflow_o = overflow_q;
    assign fault_o         = fault_q;
    assign fault_addr_o    = fault_addr_q;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Directed bench for cpu_memory_responder: a default-size instance for load/data tests
// and a 4-word instance for the loader overflow path.
module tb_cpu_memory_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load_valid, load_last, load_ready, cpu_rst;
    logic [7:0]  load_byte;
    logic [31:0] instr_addr, instr, data_addr, wdata, rdata, fault_addr;
    logic        re, we, overflow, fault;
    logic [15:0] loaded_words;

    logic        s_rst, s_load_valid, s_load_last, s_load_ready, s_cpu_rst;
    logic [7:0]  s_load_byte;
    logic [31:0] s_instr_addr, s_instr, s_rdata, s_fault_addr;
    logic        s_overflow, s_fault;
    logic [15:0] s_loaded_words;

    cpu_memory_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .load_valid_i     (load_valid),
        .load_ready_o     (load_ready),
        .load_byte_i      (load_byte),
        .load_last_i      (load_last),
        .cpu_rst_o        (cpu_rst),
        .instr_addr_i     (instr_addr),
        .instr_o          (instr),
        .data_addr_i      (data_addr),
        .mem_write_data_i (wdata),
        .mem_read_en_i    (re),
        .mem_write_en_i   (we),
        .mem_read_data_o  (rdata),
        .loaded_words_o   (loaded_words),
        .load_overflow_o  (overflow),
        .fault_o          (fault),
        .fault_addr_o     (fault_addr)
    );

    cpu_memory_responder #(.INSTR_WORDS(4), .DATA_WORDS(256)) dut_small (
        .clk_i            (clk),
        .rst_i            (s_rst),
        .load_valid_i     (s_load_valid),
        .load_ready_o     (s_load_ready),
        .load_byte_i      (s_load_byte),
        .load_last_i      (s_load_last),
        .cpu_rst_o        (s_cpu_rst),
        .instr_addr_i     (s_instr_addr),
        .instr_o          (s_instr),
        .data_addr_i      (32'h0),
        .mem_write_data_i (32'h0),
        .mem_read_en_i    (1'b0),
        .mem_write_en_i   (1'b0),
        .mem_read_data_o  (s_rdata),
        .loaded_words_o   (s_loaded_words),
        .load_overflow_o  (s_overflow),
        .fault_o          (s_fault),
        .fault_addr_o     (s_fault_addr)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%h expected=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] img [8];
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_byte = 8'h0;
        instr_addr = 32'h0; data_addr = 32'h0; wdata = 32'h0; re = 1'b0; we = 1'b0;
        s_rst = 1'b1; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_byte = 8'h0;
        s_instr_addr = 32'h0;
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        step(); step();
        expect_val("rst_cpu_rst", 32'd1);       check({31'b0, cpu_rst});
        expect_val("rst_load_ready", 32'd1);    check({31'b0, load_ready});
        expect_val("rst_loaded_words", 32'd0);  check({16'b0, loaded_words});
        expect_val("rst_overflow", 32'd0);      check({31'b0, overflow});
        expect_val("rst_fault", 32'd0);         check({31'b0, fault});
        expect_val("rst_fault_addr", 32'd0);    check(fault_addr);
        rst = 1'b0;

        // 8-byte image
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i], i == 7);
            if (i == 3) begin
                expect_val("instr_gated_in_load", 32'h0);
                instr_addr = 32'h0; #1; check(instr);
            end
        end
        expect_val("run_load_ready", 32'd0);    check({31'b0, load_ready});
        expect_val("cpu_rst_still_high", 32'd1); check({31'b0, cpu_rst});
        step();
        expect_val("cpu_rst_released", 32'd0);  check({31'b0, cpu_rst});
        expect_val("loaded_words_8b", 32'd2);   check({16'b0, loaded_words});
        instr_addr = 32'h0;
        expect_val("imem0_8b", 32'h2008_0005);  #1; check(instr);
        instr_addr = 32'h4;
        expect_val("imem1_8b", 32'h0);          #1; check(instr);
        // Loader ignored in RUN
        send_byte(8'hFF, 1'b1);
        expect_val("loader_ignored_run", 32'd2); check({16'b0, loaded_words});

        // Data write then read
        data_addr = 32'h10; wdata = 32'hDEAD_BEEF; we = 1'b1;
        expect_val("rd_after_wr", 32'hDEAD_BEEF);
        step();
        we = 1'b0; re = 1'b1; #1; check(rdata);
        // Same-cycle read/write returns the old value
        we = 1'b1; wdata = 32'h1234_5678;
        expect_val("same_cycle_old", 32'hDEAD_BEEF); #1; check(rdata);
        expect_val("same_cycle_new", 32'h1234_5678);
        step();
        we = 1'b0; #1; check(rdata);
        re = 1'b0;

        // Misaligned then out-of-range stores
        expect_val("no_fault_yet", 32'd0);      check({31'b0, fault});
        data_addr = 32'h13; wdata = 32'hAAAA_AAAA; we = 1'b1;
        step();
        data_addr = 32'h400; wdata = 32'hBBBB_BBBB;
        step();
        we = 1'b0;
        expect_val("fault_set", 32'd1);         check({31'b0, fault});
        expect_val("fault_addr_first", 32'h13); check(fault_addr);
        data_addr = 32'h10; re = 1'b1;
        expect_val("dmem_unchanged", 32'h1234_5678); #1; check(rdata);
        data_addr = 32'h13;
        expect_val("misaligned_read_zero", 32'h0); #1; check(rdata);
        re = 1'b0;

        // Reset in RUN clears sticky flags
        do_reset();
        expect_val("rerst_fault", 32'd0);       check({31'b0, fault});
        expect_val("rerst_fault_addr", 32'd0);  check(fault_addr);
        expect_val("rerst_cpu_rst", 32'd1);     check({31'b0, cpu_rst});
        expect_val("rerst_load_ready", 32'd1);  check({31'b0, load_ready});

        // 5-byte image with partial last word
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0); send_byte(8'hAB, 1'b1);
        step();
        expect_val("loaded_words_5b", 32'd2);   check({16'b0, loaded_words});
        instr_addr = 32'h0;
        expect_val("imem0_5b", 32'h1122_3344);  #1; check(instr);
        instr_addr = 32'h4;
        expect_val("imem1_pad", 32'hAB00_0000); #1; check(instr);
        instr_addr = 32'h404;
        expect_val("instr_out_of_range", 32'h0); #1; check(instr);

        // Reset mid-load discards the partial word
        do_reset();
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        step();
        expect_val("midrst_load_ready", 32'd1); check({31'b0, load_ready});
        expect_val("midrst_cpu_rst", 32'd1);    check({31'b0, cpu_rst});
        rst = 1'b0;
        send_byte(8'hCA, 1'b0); send_byte(8'hFE, 1'b0); send_byte(8'hBA, 1'b0);
        send_byte(8'hBE, 1'b1);
        step();
        instr_addr = 32'h0;
        expect_val("midrst_imem0", 32'hCAFE_BABE); #1; check(instr);
        expect_val("midrst_loaded_words", 32'd1);  check({16'b0, loaded_words});

        // Overflow on the 4-word instance
        s_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            s_load_valid = 1'b1;
            s_load_byte  = 8'(k);
            expect_val($sformatf("ovf_ready_b%0d", k), (k <= 16) ? 32'd1 : 32'd0);
            #1; check({31'b0, s_load_ready});
            step();
        end
        s_load_valid = 1'b0;
        expect_val("ovf_flag", 32'd1);          check({31'b0, s_overflow});
        expect_val("ovf_loaded_words", 32'd4);  check({16'b0, s_loaded_words});
        s_instr_addr = 32'hC;
        expect_val("ovf_imem3", 32'h0D0E_0F10); #1; check(s_instr);
        s_instr_addr = 32'h10;
        expect_val("ovf_instr_oob", 32'h0);     #1; check(s_instr);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
